// File: rtl/fdma_pkg.sv
// Shared types and width helpers for the round-robin FDMA bridge.
// Word-address width is derived from the byte-address width and data width.
package fdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_READ_END = 2'd3
    } fdma_state_e;

    function automatic int fdma_bw(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int fdma_waw(input int aw, input int dw);
        return aw - fdma_bw(dw);
    endfunction

endpackage

// File: rtl/app_fdma_rr_if.sv
// Bundle of user-side FDMA request/data signals and SDRAM-controller app signals.
// slave = the bridge's view, master = the user/controller side.
interface app_fdma_rr_if #(
    parameter int DW = 32,
    parameter int AW = 23,
    parameter int SW = 16
);
    localparam int WAW = fdma_pkg::fdma_waw(AW, DW);

    logic [AW-1:0]   fdma_waddr;
    logic            fdma_wareq;
    logic [SW-1:0]   fdma_wsize;
    logic            fdma_wbusy;
    logic [DW-1:0]   fdma_wdata;
    logic            fdma_wvalid;

    logic [AW-1:0]   fdma_raddr;
    logic            fdma_rareq;
    logic [SW-1:0]   fdma_rsize;
    logic            fdma_rbusy;
    logic [DW-1:0]   fdma_rdata;
    logic            fdma_rvalid;

    logic            sdr_init_done;
    logic            sdr_busy;
    logic            sdr_rd_en;
    logic [DW-1:0]   sdr_rd_dout;

    logic            app_wr_en;
    logic [WAW-1:0]  app_wr_addr;
    logic [DW/8-1:0] app_wr_dm;
    logic [DW-1:0]   app_wr_din;
    logic            app_rd_en;
    logic [WAW-1:0]  app_rd_addr;

    modport slave (
        input  fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata,
        input  fdma_raddr, fdma_rareq, fdma_rsize,
        input  sdr_init_done, sdr_busy, sdr_rd_en, sdr_rd_dout,
        output fdma_wbusy, fdma_wvalid, fdma_rbusy, fdma_rdata, fdma_rvalid,
        output app_wr_en, app_wr_addr, app_wr_dm, app_wr_din, app_rd_en, app_rd_addr
    );

    modport master (
        output fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata,
        output fdma_raddr, fdma_rareq, fdma_rsize,
        output sdr_init_done, sdr_busy, sdr_rd_en, sdr_rd_dout,
        input  fdma_wbusy, fdma_wvalid, fdma_rbusy, fdma_rdata, fdma_rvalid,
        input  app_wr_en, app_wr_addr, app_wr_dm, app_wr_din, app_rd_en, app_rd_addr
    );

endinterface

// File: rtl/fdma_chan_ctrl.sv
// One transfer channel: request capture, word address, words-left count and
// per-burst down-counter. Bursts never cross a MAX_BURST-aligned word boundary.
module fdma_chan_ctrl
    import fdma_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 23,
    parameter int SW        = 16,
    parameter int MAX_BURST = 256,
    localparam int BW       = fdma_bw(DW),
    localparam int WAW      = fdma_waw(AW, DW)
) (
    input  logic           fdma_clk,
    input  logic           fdma_rstn,
    input  logic           req,
    input  logic [AW-1:0]  req_addr,
    input  logic [SW-1:0]  req_size,
    input  logic           grant,
    input  logic           step,
    input  logic           done,
    output logic           busy,
    output logic           pending,
    output logic [WAW-1:0] addr,
    output logic           left_last,
    output logic           burst_last
);
    localparam int LB = $clog2(MAX_BURST);
    localparam int LW = LB + 1;
    localparam int CW = (SW > LW) ? SW : LW;

    logic           busy_q;
    logic [WAW-1:0] addr_q;
    logic [SW-1:0]  left_q;
    logic [LW-1:0]  bcnt_q;

    logic           accept;
    logic [LW-1:0]  room;
    logic [CW-1:0]  left_x;
    logic [CW-1:0]  room_x;
    logic [LW-1:0]  blen;

    assign accept = req && !busy_q && (req_size != '0);

    // Words remaining before the next MAX_BURST-aligned boundary (1..MAX_BURST).
    assign room   = LW'(MAX_BURST) - {1'b0, addr_q[LB-1:0]};
    assign left_x = CW'(left_q);
    assign room_x = CW'(room);
    assign blen   = (left_x < room_x) ? LW'(left_x) : room;

    always_ff @(posedge fdma_clk or negedge fdma_rstn) begin
        if (!fdma_rstn) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            left_q <= '0;
            bcnt_q <= '0;
        end else if (accept) begin
            busy_q <= 1'b1;
            addr_q <= req_addr[AW-1:BW];
            left_q <= req_size;
        end else begin
            if (grant) begin
                bcnt_q <= blen;
            end else if (step && (bcnt_q != '0)) begin
                bcnt_q <= bcnt_q - LW'(1);
            end
            if (step) begin
                addr_q <= addr_q + WAW'(1);
                if (left_q != '0) begin
                    left_q <= left_q - SW'(1);
                end
            end
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    generate
        if (BW > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^req_addr[BW-1:0];
        end
    endgenerate

    assign busy       = busy_q;
    assign pending    = busy_q && (left_q != '0);
    assign addr       = addr_q;
    assign left_last  = (left_q == SW'(1));
    assign burst_last = (bcnt_q == LW'(1));

endmodule

// File: rtl/app_fdma_rr.sv
// FDMA-to-SDRAM bridge: arbitrates write and read channels and issues bursts.
//   state       | meaning
//   ST_IDLE     | waiting for controller ready and a pending channel
//   ST_WRITE    | issuing write words of the current burst
//   ST_READ     | issuing read words of the current burst
//   ST_READ_END | last read burst issued, waiting for sdr_busy to drop
module app_fdma_rr
    import fdma_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 23,
    parameter int SW          = 16,
    parameter int MAX_BURST   = 256,
    parameter int RD_PRIORITY = 0
) (
    input  logic         fdma_clk,
    input  logic         fdma_rstn,
    app_fdma_rr_if.slave bus
);
    localparam int WAW = fdma_waw(AW, DW);

    fdma_state_e    state_q, state_d;
    logic           last_rd_q, last_rd_d;
    logic           wr_en, rd_en;
    logic           w_grant, r_grant, r_done, w_done;

    logic           w_busy, w_pend, w_left_last, w_burst_last;
    logic           r_busy, r_pend, r_left_last, r_burst_last;
    logic [WAW-1:0] w_addr, r_addr;

    logic           app_wr_en_q, app_rd_en_q;
    logic [WAW-1:0] app_wr_addr_q, app_rd_addr_q;

    assign w_done = wr_en && w_left_last;

    fdma_chan_ctrl #(.DW(DW), .AW(AW), .SW(SW), .MAX_BURST(MAX_BURST)) u_wr_chan (
        .fdma_clk   (fdma_clk),
        .fdma_rstn  (fdma_rstn),
        .req        (bus.fdma_wareq),
        .req_addr   (bus.fdma_waddr),
        .req_size   (bus.fdma_wsize),
        .grant      (w_grant),
        .step       (wr_en),
        .done       (w_done),
        .busy       (w_busy),
        .pending    (w_pend),
        .addr       (w_addr),
        .left_last  (w_left_last),
        .burst_last (w_burst_last)
    );

    fdma_chan_ctrl #(.DW(DW), .AW(AW), .SW(SW), .MAX_BURST(MAX_BURST)) u_rd_chan (
        .fdma_clk   (fdma_clk),
        .fdma_rstn  (fdma_rstn),
        .req        (bus.fdma_rareq),
        .req_addr   (bus.fdma_raddr),
        .req_size   (bus.fdma_rsize),
        .grant      (r_grant),
        .step       (rd_en),
        .done       (r_done),
        .busy       (r_busy),
        .pending    (r_pend),
        .addr       (r_addr),
        .left_last  (r_left_last),
        .burst_last (r_burst_last)
    );

    always_ff @(posedge fdma_clk or negedge fdma_rstn) begin
        if (!fdma_rstn) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        w_grant   = 1'b0;
        r_grant   = 1'b0;
        r_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sdr_init_done && !bus.sdr_busy) begin
                    // With both pending and no read priority, alternate on last grant.
                    if (w_pend && (!r_pend || ((RD_PRIORITY == 0) && last_rd_q))) begin
                        w_grant   = 1'b1;
                        last_rd_d = 1'b0;
                        state_d   = ST_WRITE;
                    end else if (r_pend) begin
                        r_grant   = 1'b1;
                        last_rd_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (w_burst_last || w_left_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_en = 1'b1;
                if (r_left_last) begin
                    state_d = ST_READ_END;
                end else if (r_burst_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_END: begin
                if (!bus.sdr_busy) begin
                    r_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fdma_clk or negedge fdma_rstn) begin
        if (!fdma_rstn) begin
            app_wr_en_q   <= 1'b0;
            app_rd_en_q   <= 1'b0;
            app_wr_addr_q <= '0;
            app_rd_addr_q <= '0;
        end else begin
            app_wr_en_q   <= wr_en && bus.sdr_init_done;
            app_rd_en_q   <= rd_en && bus.sdr_init_done;
            app_wr_addr_q <= bus.sdr_init_done ? w_addr : '0;
            app_rd_addr_q <= bus.sdr_init_done ? r_addr : '0;
        end
    end

    // Outputs are also gated directly so a dropping init_done silences the bus at once.
    assign bus.app_wr_en   = app_wr_en_q && bus.sdr_init_done;
    assign bus.app_rd_en   = app_rd_en_q && bus.sdr_init_done;
    assign bus.app_wr_addr = bus.sdr_init_done ? app_wr_addr_q : '0;
    assign bus.app_rd_addr = bus.sdr_init_done ? app_rd_addr_q : '0;
    assign bus.app_wr_dm   = '0;
    assign bus.app_wr_din  = bus.fdma_wdata;

    assign bus.fdma_wbusy  = w_busy;
    assign bus.fdma_wvalid = wr_en;
    assign bus.fdma_rbusy  = r_busy;
    assign bus.fdma_rvalid = bus.sdr_rd_en;
    assign bus.fdma_rdata  = bus.sdr_rd_dout;

endmodule

// File: tb/tb_app_fdma_rr.sv
// Directed bench for app_fdma_rr: expected addresses and bursts are queued when a
// request is driven and retired by a monitor watching the app_* side.
module tb_app_fdma_rr;

    localparam int TWAW = 21;

    typedef struct {
        bit rd;
        int len;
    } burst_t;

    logic clk;
    logic rstn;

    int n_vec = 0;
    int n_err = 0;

    logic [TWAW-1:0] wq[$];
    logic [TWAW-1:0] rq[$];
    burst_t          bq0[$];
    burst_t          bq1[$];

    bit pw0, pr0, pw1, pr1;
    int rw0, rr0, rw1, rr1;

    app_fdma_rr_if #(.DW(32), .AW(23), .SW(16)) b0 ();
    app_fdma_rr_if #(.DW(32), .AW(23), .SW(16)) b1 ();

    app_fdma_rr #(.DW(32), .AW(23), .SW(16), .MAX_BURST(256), .RD_PRIORITY(0)) u_dut0 (
        .fdma_clk  (clk),
        .fdma_rstn (rstn),
        .bus       (b0)
    );

    app_fdma_rr #(.DW(32), .AW(23), .SW(16), .MAX_BURST(256), .RD_PRIORITY(1)) u_dut1 (
        .fdma_clk  (clk),
        .fdma_rstn (rstn),
        .bus       (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input bit rd, input logic [TWAW-1:0] obs);
        bit have;
        logic [TWAW-1:0] e;
        have = rd ? (rq.size() != 0) : (wq.size() != 0);
        n_vec++;
        assert (have) else begin
            n_err++;
            $error("FAIL %s_addr_unexpected observed=%0h expected=none", rd ? "rd" : "wr", obs);
        end
        if (have) begin
            e = rd ? rq.pop_front() : wq.pop_front();
            check(rd ? "rd_addr" : "wr_addr", 64'(obs), 64'(e));
        end
    endtask

    task automatic end_burst(input bit which, input bit rd, input int len);
        bit have;
        burst_t e;
        have = 1'b0;
        if (which == 1'b0) begin
            if (bq0.size() != 0) begin have = 1'b1; e = bq0.pop_front(); end
        end else begin
            if (bq1.size() != 0) begin have = 1'b1; e = bq1.pop_front(); end
        end
        n_vec++;
        assert (have) else begin
            n_err++;
            $error("FAIL burst%0d_unexpected observed_len=%0d expected=none", which, len);
        end
        if (have) begin
            check(which ? "burst1_dir" : "burst0_dir", 64'(rd), 64'(e.rd));
            check(which ? "burst1_len" : "burst0_len", 64'(len), 64'(e.len));
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pw0 = 0; pr0 = 0; pw1 = 0; pr1 = 0;
                rw0 = 0; rr0 = 0; rw1 = 0; rr1 = 0;
            end else begin
                check("wr_rd_excl", 64'(b0.app_wr_en & b0.app_rd_en), 64'(0));
                if (b0.app_wr_en) pop_check(1'b0, b0.app_wr_addr);
                if (b0.app_rd_en) pop_check(1'b1, b0.app_rd_addr);
                if (pw0 && !b0.app_wr_en) end_burst(1'b0, 1'b0, rw0);
                if (pr0 && !b0.app_rd_en) end_burst(1'b0, 1'b1, rr0);
                if (pw1 && !b1.app_wr_en) end_burst(1'b1, 1'b0, rw1);
                if (pr1 && !b1.app_rd_en) end_burst(1'b1, 1'b1, rr1);
                rw0 = b0.app_wr_en ? rw0 + 1 : 0;
                rr0 = b0.app_rd_en ? rr0 + 1 : 0;
                rw1 = b1.app_wr_en ? rw1 + 1 : 0;
                rr1 = b1.app_rd_en ? rr1 + 1 : 0;
                pw0 = b0.app_wr_en; pr0 = b0.app_rd_en;
                pw1 = b1.app_wr_en; pr1 = b1.app_rd_en;
            end
        end
    endtask

    task automatic push_addrs(input bit rd, input int word, input int n);
        logic [TWAW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = TWAW'(word + i);
            if (rd) rq.push_back(a);
            else    wq.push_back(a);
        end
    endtask

    task automatic push_bursts(input bit which, input bit rd, input int word, input int n);
        int a, left, room, bl;
        burst_t e;
        a = word;
        left = n;
        while (left > 0) begin
            room = 256 - (a % 256);
            bl = (left < room) ? left : room;
            e.rd = rd;
            e.len = bl;
            if (which) bq1.push_back(e);
            else       bq0.push_back(e);
            a += bl;
            left -= bl;
        end
    endtask

    task automatic req_w(input logic [22:0] a, input int s);
        b0.fdma_waddr = a;
        b0.fdma_wsize = 16'(s);
        b0.fdma_wareq = 1'b1;
        @(negedge clk);
        b0.fdma_wareq = 1'b0;
    endtask

    task automatic req_r(input logic [22:0] a, input int s);
        b0.fdma_raddr = a;
        b0.fdma_rsize = 16'(s);
        b0.fdma_rareq = 1'b1;
        @(negedge clk);
        b0.fdma_rareq = 1'b0;
    endtask

    task automatic count_wvalid(input int n, input int budget, input string tag);
        int c, cnt;
        c = 0;
        cnt = 0;
        while (cnt < n && c < budget) begin
            @(negedge clk);
            c++;
            if (b0.fdma_wvalid) cnt++;
        end
        check(tag, 64'(cnt), 64'(n));
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int c, q;
        c = 0;
        q = 0;
        while (q < 3 && c < budget) begin
            @(negedge clk);
            c++;
            if (!b0.fdma_wbusy && !b0.fdma_rbusy && !b0.app_wr_en && !b0.app_rd_en &&
                !b1.fdma_wbusy && !b1.fdma_rbusy && !b1.app_wr_en && !b1.app_rd_en)
                q++;
            else
                q = 0;
        end
        check(tag, 64'(q), 64'(3));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wbusy"},  64'(b0.fdma_wbusy),  64'(0));
        check({tag, "_rbusy"},  64'(b0.fdma_rbusy),  64'(0));
        check({tag, "_wvalid"}, 64'(b0.fdma_wvalid), 64'(0));
        check({tag, "_wr_en"},  64'(b0.app_wr_en),   64'(0));
        check({tag, "_rd_en"},  64'(b0.app_rd_en),   64'(0));
        check({tag, "_wr_addr"}, 64'(b0.app_wr_addr), 64'(0));
        check({tag, "_rd_addr"}, 64'(b0.app_rd_addr), 64'(0));
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wq"},  64'(wq.size()),  64'(0));
        check({tag, "_rq"},  64'(rq.size()),  64'(0));
        check({tag, "_bq0"}, 64'(bq0.size()), 64'(0));
        check({tag, "_bq1"}, 64'(bq1.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] d_rd, d_wr;
        burst_t e;
        int c;
        bit found;

        rstn = 1'b0;
        b0.fdma_waddr = '0; b0.fdma_wareq = 0; b0.fdma_wsize = '0; b0.fdma_wdata = '0;
        b0.fdma_raddr = '0; b0.fdma_rareq = 0; b0.fdma_rsize = '0;
        b0.sdr_init_done = 1; b0.sdr_busy = 0; b0.sdr_rd_en = 0; b0.sdr_rd_dout = '0;
        b1.fdma_waddr = '0; b1.fdma_wareq = 0; b1.fdma_wsize = '0; b1.fdma_wdata = '0;
        b1.fdma_raddr = '0; b1.fdma_rareq = 0; b1.fdma_rsize = '0;
        b1.sdr_init_done = 1; b1.sdr_busy = 0; b1.sdr_rd_en = 0; b1.sdr_rd_dout = '0;

        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        fork monitor(); join_none
        @(negedge clk);
        check_idle_outputs("release");

        // Pass-through paths
        d_rd = $urandom;
        d_wr = $urandom;
        b0.sdr_rd_en = 1'b1;
        b0.sdr_rd_dout = d_rd;
        b0.fdma_wdata = d_wr;
        #1;
        check("pt_rvalid", 64'(b0.fdma_rvalid), 64'(1));
        check("pt_rdata",  64'(b0.fdma_rdata),  64'(d_rd));
        check("pt_wr_din", 64'(b0.app_wr_din),  64'(d_wr));
        check("pt_wr_dm",  64'(b0.app_wr_dm),   64'(0));
        b0.sdr_rd_en = 1'b0;
        #1;
        check("pt_rvalid_lo", 64'(b0.fdma_rvalid), 64'(0));
        @(negedge clk);

        // Simultaneous requests: alternate (dut0) vs read-priority (dut1)
        push_addrs(1'b0, 'h1000, 512);
        push_addrs(1'b1, 'h2000, 512);
        e.len = 256;
        e.rd = 0; bq0.push_back(e); e.rd = 1; bq0.push_back(e);
        e.rd = 0; bq0.push_back(e); e.rd = 1; bq0.push_back(e);
        e.rd = 1; bq1.push_back(e); e.rd = 1; bq1.push_back(e);
        e.rd = 0; bq1.push_back(e); e.rd = 0; bq1.push_back(e);
        b0.fdma_waddr = 23'h4000; b0.fdma_wsize = 16'd512; b0.fdma_wareq = 1;
        b0.fdma_raddr = 23'h8000; b0.fdma_rsize = 16'd512; b0.fdma_rareq = 1;
        b1.fdma_waddr = 23'h4000; b1.fdma_wsize = 16'd512; b1.fdma_wareq = 1;
        b1.fdma_raddr = 23'h8000; b1.fdma_rsize = 16'd512; b1.fdma_rareq = 1;
        @(negedge clk);
        b0.fdma_wareq = 0; b0.fdma_rareq = 0; b1.fdma_wareq = 0; b1.fdma_rareq = 0;
        wait_quiet(4000, "arb_quiet");
        check_drained("arb");

        // 300-word write across a burst boundary
        push_addrs(1'b0, 0, 300);
        push_bursts(1'b0, 1'b0, 0, 300);
        req_w(23'h0, 300);
        count_wvalid(300, 2000, "w300_count");
        check("w300_busy_last", 64'(b0.fdma_wbusy), 64'(1));
        @(negedge clk);
        check("w300_busy_drop", 64'(b0.fdma_wbusy), 64'(0));
        check("w300_wvalid_off", 64'(b0.fdma_wvalid), 64'(0));
        wait_quiet(100, "w300_quiet");
        check_drained("w300");

        // 8-word read straddling 0x100, READ_END held by sdr_busy
        push_addrs(1'b1, 'hFC, 8);
        push_bursts(1'b0, 1'b1, 'hFC, 8);
        req_r(23'h3F0, 8);
        c = 0;
        found = 0;
        while (!found && c < 100) begin
            @(negedge clk);
            c++;
            if (b0.app_rd_en && b0.app_rd_addr == TWAW'('h100)) found = 1;
        end
        check("r8_second_burst", 64'(found), 64'(1));
        b0.sdr_busy = 1'b1;
        repeat (6) @(negedge clk);
        check("r8_rbusy_hold", 64'(b0.fdma_rbusy), 64'(1));
        check("r8_rd_en_done", 64'(b0.app_rd_en), 64'(0));
        b0.sdr_busy = 1'b0;
        @(negedge clk);
        check("r8_rbusy_clear", 64'(b0.fdma_rbusy), 64'(0));
        wait_quiet(100, "r8_quiet");
        check_drained("r8");

        // Size-0 request dropped, second request while busy dropped
        req_w(23'h200, 0);
        for (int i = 0; i < 4; i++) begin
            check("sz0_wbusy", 64'(b0.fdma_wbusy), 64'(0));
            check("sz0_wvalid", 64'(b0.fdma_wvalid), 64'(0));
            @(negedge clk);
        end
        push_addrs(1'b0, 'h40, 10);
        push_bursts(1'b0, 1'b0, 'h40, 10);
        req_w(23'h100, 10);
        check("busy_req_wbusy", 64'(b0.fdma_wbusy), 64'(1));
        req_w(23'h8000, 5);
        wait_quiet(200, "busy_req_quiet");
        check_drained("busy_req");

        // Held off by sdr_init_done
        b0.sdr_init_done = 1'b0;
        push_addrs(1'b0, 'h200, 4);
        push_bursts(1'b0, 1'b0, 'h200, 4);
        req_w(23'h800, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("init_wvalid",  64'(b0.fdma_wvalid), 64'(0));
            check("init_wr_en",   64'(b0.app_wr_en),   64'(0));
            check("init_wr_addr", 64'(b0.app_wr_addr), 64'(0));
            check("init_rd_addr", 64'(b0.app_rd_addr), 64'(0));
        end
        check("init_wbusy", 64'(b0.fdma_wbusy), 64'(1));
        b0.sdr_init_done = 1'b1;
        wait_quiet(200, "init_quiet");
        check_drained("init");

        // Reset mid-burst, then a fresh request
        push_addrs(1'b0, 'h300, 256);
        push_bursts(1'b0, 1'b0, 'h300, 256);
        req_w(23'hC00, 256);
        count_wvalid(100, 1000, "rst_reach100");
        #1;
        rstn = 1'b0;
        wq.delete();
        bq0.delete();
        #1;
        check_idle_outputs("rst_async");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_resume_wvalid", 64'(b0.fdma_wvalid), 64'(0));
            check("rst_no_resume_wbusy",  64'(b0.fdma_wbusy),  64'(0));
        end
        push_addrs(1'b0, 'h123, 3);
        push_bursts(1'b0, 1'b0, 'h123, 3);
        req_w(23'h48C, 3);
        wait_quiet(100, "rst_fresh_quiet");
        check_drained("rst_fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
